// File: rtl/reg_file_if.sv
// Register file access bundle: write port, two read ports and the write counter.
// The master drives addresses, write data and write enable. The slave (the
// register file) returns read data, per-port valid flags and the write count.
interface reg_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic signed [DATA_WIDTH-1:0] IN;
    logic        [ADDR_WIDTH-1:0] INADDRESS;
    logic                         WRITE;
    logic        [ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic        [ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic signed [DATA_WIDTH-1:0] OUT1;
    logic signed [DATA_WIDTH-1:0] OUT2;
    logic                         OUT1_VALID;
    logic                         OUT2_VALID;
    logic        [7:0]            WRITE_COUNT;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2, OUT1_VALID, OUT2_VALID, WRITE_COUNT
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2, OUT1_VALID, OUT2_VALID, WRITE_COUNT
    );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file feeding the ALU operand inputs.
// It has two combinational read ports, one synchronous write port and a
// synchronous active-high clear. Each register has a valid bit that marks
// whether it has been written since reset. A saturating 8-bit counter records
// the number of accepted writes.
// Optional macro REGFILE_BYPASS_EN: a write in progress is forwarded to any read
// port that addresses the same register before the clock edge. Without the
// macro, a read port shows the stored value until the edge.
module reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    reg_file_if.slave     bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic signed [DATA_WIDTH-1:0] regs_q [NREGS];
    logic        [NREGS-1:0]      valid_q;
    logic        [7:0]            wcount_q;
    logic        [7:0]            wcount_d;

    logic signed [DATA_WIDTH-1:0] rd1_data;
    logic signed [DATA_WIDTH-1:0] rd2_data;
    logic                         rd1_vld;
    logic                         rd2_vld;

    // Write counter next state: count accepted writes and hold at 255.
    always_comb begin
        wcount_d = wcount_q;
        if (bus.WRITE && (wcount_q != 8'hFF)) begin
            wcount_d = wcount_q + 8'd1;
        end
    end

    // Storage update: clear takes priority and drops a coincident write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            valid_q  <= '0;
            wcount_q <= '0;
        end else begin
            if (bus.WRITE) begin
                regs_q[bus.INADDRESS]  <= bus.IN;
                valid_q[bus.INADDRESS] <= 1'b1;
            end
            wcount_q <= wcount_d;
        end
    end

    // Read ports: zero-latency lookup, with optional write-through forwarding.
    always_comb begin
        rd1_data = regs_q[bus.OUT1ADDRESS];
        rd1_vld  = valid_q[bus.OUT1ADDRESS];
        rd2_data = regs_q[bus.OUT2ADDRESS];
        rd2_vld  = valid_q[bus.OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
        if (bus.WRITE && !RESET && (bus.INADDRESS == bus.OUT1ADDRESS)) begin
            rd1_data = bus.IN;
            rd1_vld  = 1'b1;
        end
        if (bus.WRITE && !RESET && (bus.INADDRESS == bus.OUT2ADDRESS)) begin
            rd2_data = bus.IN;
            rd2_vld  = 1'b1;
        end
`endif
    end

    assign bus.OUT1        = rd1_data;
    assign bus.OUT2        = rd2_data;
    assign bus.OUT1_VALID  = rd1_vld;
    assign bus.OUT2_VALID  = rd2_vld;
    assign bus.WRITE_COUNT = wcount_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. A behavioural model built from arrays
// tracks the register contents, valid flags and write count. A compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios also pin a set of hand-computed literal values.
module tb_reg_file;
    localparam int DW = 8;
    localparam int AW = 3;

    logic CLK;
    logic RESET;

    reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    // Behavioural model.
    logic signed [DW-1:0] m_regs [8];
    bit                   m_valid [8];
    int                   m_cnt;
    bit                   model_ok = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit fwd(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return bus.WRITE && !RESET && (bus.INADDRESS == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (fwd(a)) return bus.IN;
        return m_regs[a];
    endfunction

    function automatic logic exp_vld(input logic [AW-1:0] a);
        if (fwd(a)) return 1'b1;
        return m_valid[a];
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i]  = '0;
                m_valid[i] = 1'b0;
            end
            m_cnt    = 0;
            model_ok = 1'b1;
        end else if (bus.WRITE) begin
            m_regs[bus.INADDRESS]  = bus.IN;
            m_valid[bus.INADDRESS] = 1'b1;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("cmp_out1", {24'd0, bus.OUT1}, {24'd0, exp_data(bus.OUT1ADDRESS)});
            chk("cmp_out2", {24'd0, bus.OUT2}, {24'd0, exp_data(bus.OUT2ADDRESS)});
            chk("cmp_v1", {31'd0, bus.OUT1_VALID}, {31'd0, exp_vld(bus.OUT1ADDRESS)});
            chk("cmp_v2", {31'd0, bus.OUT2_VALID}, {31'd0, exp_vld(bus.OUT2ADDRESS)});
            chk("cmp_cnt", {24'd0, bus.WRITE_COUNT}, m_cnt);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.WRITE = 1'b1;
        bus.INADDRESS = a;
        bus.IN = d;
        step();
        bus.WRITE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        bus.IN = '0;
        bus.INADDRESS = '0;
        bus.WRITE = 1'b0;
        bus.OUT1ADDRESS = '0;
        bus.OUT2ADDRESS = 3'd7;

        // Reset state.
        step();
        RESET = 1'b0;
        #1;
        chk("rst_out1", bus.OUT1, 0);
        chk("rst_out2", bus.OUT2, 0);
        chk("rst_v1", bus.OUT1_VALID, 0);
        chk("rst_v2", bus.OUT2_VALID, 0);
        chk("rst_cnt", bus.WRITE_COUNT, 0);

        // Write then read two registers.
        do_write(3'd2, 8'd15);
        do_write(3'd5, 8'd11);
        bus.OUT1ADDRESS = 3'd2;
        bus.OUT2ADDRESS = 3'd5;
        #1;
        chk("wr_out1", bus.OUT1, 15);
        chk("wr_out2", bus.OUT2, 11);
        chk("wr_v1", bus.OUT1_VALID, 1);
        chk("wr_v2", bus.OUT2_VALID, 1);
        chk("wr_cnt", bus.WRITE_COUNT, 2);
        chk("wr_and", bus.OUT1 & bus.OUT2, 11);

        // Negative value, both ports on the same register.
        do_write(3'd3, 8'b11010100);
        bus.OUT1ADDRESS = 3'd3;
        bus.OUT2ADDRESS = 3'd3;
        #1;
        chk("sgn_out1", $signed(bus.OUT1), -44);
        chk("sgn_out2", $signed(bus.OUT2), -44);
        chk("sgn_v1", bus.OUT1_VALID, 1);
        bus.OUT2ADDRESS = 3'd4;
        #1;
        chk("unwr_v2", bus.OUT2_VALID, 0);

        // Reset and write on the same edge: the reset wins.
        RESET = 1'b1;
        do_write(3'd1, 8'd99);
        RESET = 1'b0;
        bus.OUT1ADDRESS = 3'd1;
        #1;
        chk("rvw_out1", bus.OUT1, 0);
        chk("rvw_v1", bus.OUT1_VALID, 0);
        chk("rvw_cnt", bus.WRITE_COUNT, 0);

        // Read during write to the same address.
        do_write(3'd6, 8'd10);
        bus.WRITE = 1'b1;
        bus.INADDRESS = 3'd6;
        bus.IN = 8'd20;
        bus.OUT1ADDRESS = 3'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_pre", bus.OUT1, 20);
`else
        chk("rdw_pre", bus.OUT1, 10);
`endif
        step();
        bus.WRITE = 1'b0;
        #1;
        chk("rdw_post", bus.OUT1, 20);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            RESET = ($urandom_range(0, 31) == 0);
            bus.WRITE = $urandom_range(0, 1);
            bus.INADDRESS = AW'($urandom);
            bus.IN = DW'($urandom);
            bus.OUT1ADDRESS = AW'($urandom);
            bus.OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? bus.INADDRESS : AW'($urandom);
            step();
        end
        RESET = 1'b0;
        bus.WRITE = 1'b0;

        // Counter saturation, then clear.
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        bus.WRITE = 1'b1;
        for (int n = 0; n < 260; n++) begin
            bus.INADDRESS = AW'($urandom);
            bus.IN = DW'($urandom);
            step();
        end
        bus.WRITE = 1'b0;
        #1;
        chk("sat_cnt", bus.WRITE_COUNT, 255);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        #1;
        chk("sat_clr", bus.WRITE_COUNT, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 8 x 8-bit register file for the single-cycle processor.
- Sits directly upstream of the ALU function units. OUT1 and OUT2 drive the ALU A/B operand inputs; the ALU result returns on IN.
- Two combinational read ports, one synchronous write port, synchronous clear.
- Per-register valid bit: flags a register that has not been written since reset, so the bench can catch use of uninitialised operands.

Parameters:
- DATA_WIDTH, 8, width of each register and of IN/OUT1/OUT2.
- ADDR_WIDTH, 3, address width; register count is 2**ADDR_WIDTH (8 at default).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset; sampled on the rising CLK edge.
- IN  input  DATA_WIDTH  signed write data (ALU result).
- INADDRESS  input  ADDR_WIDTH  write register index.
- WRITE  input  1  write enable.
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 register index.
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 register index.
- OUT1  output  DATA_WIDTH  signed read data port 1 (ALU operand A).
- OUT2  output  DATA_WIDTH  signed read data port 2 (ALU operand B).
- OUT1_VALID  output  1  1 when the register addressed by OUT1ADDRESS has been written since the last reset.
- OUT2_VALID  output  1  same, for port 2.
- WRITE_COUNT  output  8  count of accepted writes since reset; saturates at 255.

Behaviour:
- Storage:
  - regs[0..2**ADDR_WIDTH-1], each DATA_WIDTH bits.
  - valid[0..2**ADDR_WIDTH-1], 1 bit each.
  - wcount, 8 bits.
  - Register 0 is an ordinary register, not hardwired to zero.
- Reset, synchronous:
  - On a rising CLK edge with RESET=1: all regs <= 0, all valid <= 0, wcount <= 0.
  - RESET has priority over WRITE in the same cycle; the write is discarded and not counted.
  - Outputs after reset: OUT1=OUT2=0, OUT1_VALID=OUT2_VALID=0, WRITE_COUNT=0.
  - Before the first reset edge, contents are X; the bench must not check outputs then.
- Write:
  - On a rising CLK edge with RESET=0 and WRITE=1: regs[INADDRESS] <= IN, valid[INADDRESS] <= 1, and wcount <= wcount+1 unless wcount==255.
  - WRITE=0: no state change.
  - Rewriting an already-valid register overwrites the data and still increments the counter.
- Read:
  - Purely combinational, zero-cycle latency: OUT1=regs[OUT1ADDRESS], OUT1_VALID=valid[OUT1ADDRESS]; likewise port 2.
  - Both ports may address the same register; both return identical data.
  - Read data is stored bits only, with no sign extension or other transformation.
- Read-during-write, same address, same cycle:
  - Base build: OUT shows the old value until the edge, then the new value immediately after.
  - This is the single-cycle contract: the ALU consumes pre-edge operands.
- Address wrap: addresses are exactly ADDR_WIDTH bits, so no out-of-range case exists.
- Counter saturation: WRITE_COUNT holds at 255; it clears only on RESET.
- Reset mid-operation: RESET asserted between writes clears everything at that edge. WRITE held high in the following cycle (RESET=0) writes normally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when WRITE=1, RESET=0 and INADDRESS==OUTnADDRESS, OUTn=IN and OUTn_VALID=1 combinationally, before the edge (write-through forwarding). Applies to both ports independently.
- Not defined: no forwarding; read-during-write behaves as in the base build.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert RESET for 1 edge, OUT1ADDRESS=0, OUT2ADDRESS=7 -> OUT1=OUT2=0, OUT1_VALID=OUT2_VALID=0, WRITE_COUNT=0.
- Write/read: write 8'd15 to r2 and 8'd11 to r5 on successive edges; read ports r2/r5 -> OUT1=15, OUT2=11, both valid=1, WRITE_COUNT=2; OUT1 & OUT2 = 11 at the ALU.
- Signed value: write 8'b11010100 to r3 -> reading r3 on both ports gives -44 on both, valid=1; r4 still valid=0.
- Reset vs write: RESET=1 and WRITE=1 (IN=8'd99 to r1) on the same edge -> r1 reads 0, valid=0, WRITE_COUNT=0.
- Read-during-write: r6 holds 10; drive IN=20, INADDRESS=6, WRITE=1, OUT1ADDRESS=6. Before the edge -> OUT1=10 (base) or 20 (REGFILE_BYPASS_EN). After the edge -> 20 in both builds.
- Saturation: 260 consecutive writes with WRITE held high -> WRITE_COUNT stops at 255; one RESET edge -> 0.
